// File: rtl/shift_seq.sv
// -----------------------------------------------------------------------------
// shift_seq_pkg / shift_seq
//
// Purpose:
//   Multi-cycle shift sequencer for low-area MIPS configurations. A full-range
//   SLL/SRL/SRA/ROR is carried out by applying a narrow shift step of at most
//   MAX_STEP = 2^STEP_WIDTH-1 bit positions per clock to an internal
//   accumulator. The request side (execute) and the result side (writeback)
//   each use a valid/ready handshake. Operation and amount are latched when
//   the request is accepted, so the issuing stage is free to change its
//   operands right after the accept edge.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_valid      request valid
//   o_ready      request accepted when i_valid & o_ready (high only in IDLE)
//   i_operation  OP_SLL / OP_SRL / OP_SRA / OP_ROR
//   i_amount     shift distance, 0..DATA_WIDTH-1
//   i_din        operand
//   o_valid      result valid (registered, high in DONE)
//   i_ready      result consumer ready
//   o_dout       result (registered, held while o_valid & !i_ready)
//   o_busy       high while in SHIFT or DONE
// -----------------------------------------------------------------------------

package shift_seq_pkg;

    // Shift operation encodings shared with the execute stage.
    localparam logic [1:0] OP_SLL = 2'd0;
    localparam logic [1:0] OP_SRL = 2'd1;
    localparam logic [1:0] OP_SRA = 2'd2;
    localparam logic [1:0] OP_ROR = 2'd3;

    // Ceiling log2, usable in constant expressions.
    function automatic int log(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

module shift_seq
    import shift_seq_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int STEP_WIDTH = 2,
    localparam int ADDR_WIDTH = log(DATA_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [1:0]            i_operation,
    input  logic [ADDR_WIDTH-1:0] i_amount,
    input  logic [DATA_WIDTH-1:0] i_din,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic                  o_busy
);

    localparam int MAX_STEP = (1 << STEP_WIDTH) - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [ADDR_WIDTH-1:0] r_rem;
    logic [1:0]            r_op;
    logic                  r_ready;
    logic                  r_valid;
    logic                  r_busy;
    logic [DATA_WIDTH-1:0] r_dout;

    logic [STEP_WIDTH-1:0] w_step;
    logic [DATA_WIDTH-1:0] w_shifted;

    // One narrow shift step of the accumulator. Because SRA refills from the
    // current MSB and ROR wraps bit 0 into the MSB, chaining steps gives the
    // same result as one shift by the summed distance.
    function automatic logic [DATA_WIDTH-1:0] step_shift(
        input logic [DATA_WIDTH-1:0] a,
        input logic [1:0]            op,
        input logic [STEP_WIDTH-1:0] s
    );
        logic [DATA_WIDTH-1:0] r;
        r = a;
        case (op)
            OP_SLL:  r = a << s;
            OP_SRL:  r = a >> s;
            OP_SRA:  r = $unsigned($signed(a) >>> s);
            // A left shift by DATA_WIDTH (s == 0) yields zero, leaving a intact.
            OP_ROR:  r = (a >> s) | (a << (DATA_WIDTH - int'(s)));
            default: r = a;
        endcase
        return r;
    endfunction

    // step = min(rem, MAX_STEP); never zero while in SHIFT because SHIFT is
    // only entered or kept with rem != 0.
    always_comb begin
        w_step = r_rem[STEP_WIDTH-1:0];
        if (r_rem > ADDR_WIDTH'(MAX_STEP)) begin
            w_step = STEP_WIDTH'(MAX_STEP);
        end
        w_shifted = step_shift(r_acc, r_op, w_step);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_rem   <= '0;
            r_op    <= OP_SLL;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_dout  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_acc   <= i_din;
                        r_op    <= i_operation;
                        r_rem   <= i_amount;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= (i_amount == '0) ? DONE : SHIFT;
                    end
                end

                SHIFT: begin
                    r_acc <= w_shifted;
                    r_rem <= r_rem - ADDR_WIDTH'(w_step);
                    if (r_rem == ADDR_WIDTH'(w_step)) begin
                        r_state <= DONE;
                    end
                end

                DONE: begin
                    // First DONE cycle publishes the accumulator; afterwards
                    // the result is held until the consumer takes it.
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                        r_dout  <= r_acc;
                    end else if (i_ready) begin
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_busy  = r_busy;
    assign o_dout  = r_dout;

endmodule

// File: tb/tb_shift_seq.sv
// -----------------------------------------------------------------------------
// tb_shift_seq
//
// Purpose:
//   Self-checking bench for shift_seq (DATA_WIDTH=32, STEP_WIDTH=2). Directed
//   cases, backpressure, asynchronous reset mid-shift and randomized
//   back-to-back requests are compared against a whole-word shift model.
//   Outputs are sampled 1 time unit after the rising clock edge.
// -----------------------------------------------------------------------------

module tb_shift_seq;
    import shift_seq_pkg::*;

    localparam int DW       = 32;
    localparam int MAX_STEP = 3;

    logic        clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_operation;
    logic [4:0]  i_amount;
    logic [31:0] i_din;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_dout;
    logic        o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    shift_seq #(
        .DATA_WIDTH (DW),
        .STEP_WIDTH (2)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_operation (i_operation),
        .i_amount    (i_amount),
        .i_din       (i_din),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_dout      (o_dout),
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Whole-word reference: a single shift by the full amount.
    function automatic logic [31:0] ref_shift(input logic [1:0] op, input int amt,
                                              input logic [31:0] din);
        logic [63:0] dbl;
        logic [31:0] fill;
        case (op)
            2'd0:    return din << amt;
            2'd1:    return din >> amt;
            2'd2: begin
                fill = din[31] ? ~(32'hFFFF_FFFF >> amt) : 32'h0;
                return (din >> amt) | fill;
            end
            default: begin
                dbl = {din, din} >> amt;
                return dbl[31:0];
            end
        endcase
    endfunction

    function automatic int ref_lat(input int amt);
        return 1 + (amt + MAX_STEP - 1) / MAX_STEP;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request, measure latency, optionally hold the result under
    // backpressure while wiggling the request inputs, then release it.
    task automatic run_txn(input string tag, input logic [1:0] op, input int amt,
                           input logic [31:0] din, input logic [31:0] exp_dout,
                           input int exp_lat, input int hold);
        int   cnt;
        logic busy_ok;
        chk({tag, ".ready"}, 32'(o_ready), 32'd1);
        i_valid     = 1'b1;
        i_operation = op;
        i_amount    = 5'(amt);
        i_din       = din;
        @(posedge clk); #1;
        // Change operands after acceptance; they must not matter.
        i_valid     = 1'b0;
        i_din       = $urandom;
        i_operation = 2'($urandom);
        i_amount    = 5'($urandom);
        cnt     = 0;
        busy_ok = 1'b1;
        while (o_valid !== 1'b1 && cnt < 200) begin
            if (o_busy !== 1'b1 || o_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
            cnt++;
        end
        chk({tag, ".latency"}, 32'(cnt), 32'(exp_lat));
        chk({tag, ".dout"}, o_dout, exp_dout);
        chk({tag, ".busy"}, 32'(busy_ok & o_busy), 32'd1);
        for (int h = 0; h < hold; h++) begin
            i_valid     = 1'($urandom);
            i_din       = $urandom;
            i_operation = 2'($urandom);
            i_amount    = 5'($urandom);
            @(posedge clk); #1;
            chk({tag, ".hold_dout"}, o_dout, exp_dout);
            chk({tag, ".hold_valid"}, 32'(o_valid), 32'd1);
            chk({tag, ".hold_ready"}, 32'(o_ready), 32'd0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        chk({tag, ".rel_valid"}, 32'(o_valid), 32'd0);
        chk({tag, ".rel_ready"}, 32'(o_ready), 32'd1);
        chk({tag, ".rel_busy"}, 32'(o_busy), 32'd0);
        $display("txn %s op=%0d amt=%0d din=0x%08h dout=0x%08h exp=0x%08h lat=%0d exp_lat=%0d",
                 tag, op, amt, din, exp_dout == o_dout ? exp_dout : 32'h0, exp_dout, cnt, exp_lat);
    endtask

    initial begin
        logic [1:0]  op;
        int          amt;
        logic [31:0] din;

        i_rst       = 1'b1;
        i_valid     = 1'b0;
        i_operation = 2'd0;
        i_amount    = 5'd0;
        i_din       = 32'h0;
        i_ready     = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset.valid", 32'(o_valid), 32'd0);
        chk("reset.dout", o_dout, 32'h0);
        chk("reset.busy", 32'(o_busy), 32'd0);
        i_rst = 1'b0;
        @(posedge clk); #1;
        chk("reset.ready", 32'(o_ready), 32'd1);

        // Directed cases.
        run_txn("sll31", OP_SLL, 31, 32'h0000_0001, 32'h8000_0000, 12, 0);
        run_txn("sra4", OP_SRA, 4, 32'h8000_0000, 32'hF800_0000, 3, 0);
        run_txn("srl5", OP_SRL, 5, 32'hF000_000F, 32'h0780_0000, 3, 0);
        run_txn("ror8", OP_ROR, 8, 32'h1234_5678, 32'h7812_3456, 4, 0);
        run_txn("sll0", OP_SLL, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 0);
        run_txn("srl0", OP_SRL, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 0);
        run_txn("sra0", OP_SRA, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 0);
        run_txn("ror0", OP_ROR, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 0);

        // Backpressure: result held 5 cycles while request inputs toggle.
        run_txn("bp_ror7", OP_ROR, 7, 32'h0000_00FF, 32'hFE00_0001, 4, 5);

        // Asynchronous reset in the middle of a long shift.
        run_txn("pre_rst", OP_SRA, 1, 32'hA5A5_A5A4, 32'hD2D2_D2D2, 2, 0);
        i_valid     = 1'b1;
        i_operation = OP_SLL;
        i_amount    = 5'd31;
        i_din       = 32'h0000_0001;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst.busy_before", 32'(o_busy), 32'd1);
        #2;
        i_rst = 1'b1;
        #1;
        chk("midrst.valid", 32'(o_valid), 32'd0);
        chk("midrst.dout", o_dout, 32'h0);
        chk("midrst.busy", 32'(o_busy), 32'd0);
        #1;
        i_rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst.no_result", 32'(o_valid), 32'd0);
        run_txn("post_rst", OP_SLL, 2, 32'h0000_0003, 32'h0000_000C, 2, 0);

        // Randomized back-to-back requests: every amount 0..31, all ops.
        for (int t = 0; t < 48; t++) begin
            op  = 2'(t ^ (t >> 2));
            amt = (t < 32) ? t : int'($urandom_range(0, 31));
            din = $urandom;
            run_txn($sformatf("rnd%0d", t), op, amt, din, ref_shift(op, amt, din),
                    ref_lat(amt), int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
- Multi-cycle shift sequencer for low-area configurations of the MIPS core.
- Performs a full-range SLL/SRL/SRA/ROR by iterating a narrow shift step of at most 2^STEP_WIDTH-1 bit positions per clock over an internal accumulator.
- Sits between the execute stage (request side, valid/ready) and writeback (result side, valid/ready).
- Amount and operation are latched at acceptance, so the issuing stage may change its operands immediately afterwards.

Parameters:
- DATA_WIDTH, 32: operand/result width; power of two, >= 8.
- STEP_WIDTH, 2: width of the per-cycle step amount; max step MAX_STEP = 2^STEP_WIDTH-1; must be < log2(DATA_WIDTH).
- ADDR_WIDTH (localparam), log2(DATA_WIDTH): shift-amount width, computed with the shared log() function.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  request valid.
- o_ready  out  1  request accepted when i_valid & o_ready.
- i_operation  in  2  SLL/SRL/SRA/ROR, encoded with the shared local-parameter constants.
- i_amount  in  ADDR_WIDTH  shift distance, 0..DATA_WIDTH-1.
- i_din  in  DATA_WIDTH  operand.
- o_valid  out  1  result valid.
- i_ready  in  1  result consumer ready.
- o_dout  out  DATA_WIDTH  result.
- o_busy  out  1  high in SHIFT and DONE states.

Behaviour:
- Reset (async, any state, including mid-operation):
  - state=IDLE; o_valid=0; o_dout=0; accumulator=0; remaining=0; latched op=SLL.
  - o_ready=1 from the first cycle after reset deassertion.
  - An aborted operation produces no result.
- States:
  - IDLE: o_ready=1, o_valid=0.
    - On accept: acc<=i_din, op<=i_operation, rem<=i_amount.
    - If i_amount==0, go to DONE; otherwise go to SHIFT.
  - SHIFT: o_ready=0, o_valid=0.
    - Each cycle: step=min(rem, MAX_STEP); acc<=shift(acc, op, step); rem<=rem-step.
    - When rem==step (rem becomes 0), go to DONE.
  - DONE: o_valid=1, o_dout=acc, o_ready=0.
    - On i_ready, go to IDLE. A new request is accepted no earlier than the following cycle.
- Per-step arithmetic on the DATA_WIDTH accumulator:
  - SLL: zero fill from the right.
  - SRL: zero fill from the left.
  - SRA: replicate the current acc MSB; repeated steps preserve the sign.
  - ROR: bits shifted out at bit 0 re-enter at the MSB.
  - Iterating steps is exactly equivalent to a single shift by the total amount.
- Latency from the accept edge to o_valid high: 1 + ceil(amount/MAX_STEP) clocks. Amount 0 takes 1 clock.
- o_dout is registered and tracks acc. While o_valid=1 and i_ready=0, o_dout and o_valid hold stable indefinitely.
- i_valid, i_operation, i_amount and i_din are ignored whenever o_ready=0. Operand changes after acceptance do not affect the result.
- rem never underflows; step is never 0 while in SHIFT.
- No X propagation: every combinational decode has a defined default.

Test Plan:
- SLL, i_din=0x0000_0001, i_amount=31 (STEP_WIDTH=2) -> o_dout=0x8000_0000, o_valid 12 clocks after accept; o_busy high throughout.
- SRA, i_din=0x8000_0000, i_amount=4 -> 0xF800_0000 after 3 clocks. SRL, i_din=0xF000_000F, i_amount=5 -> 0x0780_0000 after 3 clocks.
- ROR, i_din=0x1234_5678, i_amount=8 -> 0x7812_3456 after 4 clocks. Amount 0 with any op, i_din=0xDEAD_BEEF -> 0xDEAD_BEEF after 1 clock.
- Backpressure: hold i_ready=0 for 5 clocks in DONE while toggling i_valid and operands -> o_dout and o_valid stable, o_ready=0, no request accepted; i_ready=1 -> IDLE the next clock.
- Reset asserted asynchronously mid-SHIFT -> o_valid=0, o_dout=0 immediately; next request (SLL 0x3 by 2) -> 0x0000_000C with normal latency.
- Randomized back-to-back requests against a reference shift model, covering all 4 ops and amounts 0..31 -> every result and latency matches.
